ic_wdata_route: RTL and testbench
=================================

// Module: ic_wdata_route
// PURPOSE
//  Write-data router in the AXI fabric: sits between one master W channel and all slave W ports,
//  including the decode-error slave (which accepts beats with WREADY=1 and counts WLAST).
//  Queues the slave index of each accepted AW (AWSLV from the address decoder) in order.
//  Steers each W burst to the slave at the queue head; pops on the WLAST handshake.
//  Exports CMD_FULL so the fabric throttles AW while the queue is full.
// PARAMETERS
//  SLV_NUM    3   slave ports incl. decode-error slave (index SLV_NUM-1)
//  SLV_BITS   2   width of slave index, >= clog2(SLV_NUM)
//  CMD_DEPTH  4   outstanding AW entries; power of 2, >= 2
//  DATA_BITS  64  W data width
// PORTS
//  clk        in   1             fabric clock, all logic on rising edge
//  reset      in   1             asynchronous, active-high
//  AWVALID    in   1             master AW valid (observed only)
//  AWREADY    in   1             final master AWREADY after fabric gating (observed only)
//  AWSLV      in   SLV_BITS      decoded slave index for current AW
//  WVALID     in   1             master W valid
//  WDATA      in   DATA_BITS     master W data
//  WSTRB      in   DATA_BITS/8   master W strobes
//  WLAST      in   1             master W last beat
//  WREADY     out  1             to master
//  S_WVALID   out  SLV_NUM       one-hot per-slave W valid
//  S_WREADY   in   SLV_NUM       per-slave W ready
//  S_WDATA    out  DATA_BITS     broadcast to all slaves
//  S_WSTRB    out  DATA_BITS/8   broadcast
//  S_WLAST    out  1             broadcast
//  CMD_FULL   out  1             queue full; fabric ANDs master AWREADY with ~CMD_FULL
//  CMD_EMPTY  out  1             queue empty
//  CMD_ERR    out  1             sticky: push while full or AWSLV >= SLV_NUM
// BEHAVIOUR
//  Reset (async): queue empty, rd/wr pointers 0, count 0, CMD_EMPTY=1, CMD_FULL=0, CMD_ERR=0;
//   hence S_WVALID=0, WREADY=0 during and after reset until a push.
//  Queue: CMD_DEPTH x SLV_BITS regs, wr_ptr/rd_ptr log2(CMD_DEPTH) bits wrapping modulo depth,
//   count log2(CMD_DEPTH)+1 bits; CMD_FULL=(count==CMD_DEPTH), CMD_EMPTY=(count==0), both registered-derived.
//  push = AWVALID & AWREADY; writes AWSLV at wr_ptr, wr_ptr+1.
//  pop  = WVALID & WREADY & WLAST; rd_ptr+1.
//  push & pop same cycle: count unchanged, both pointers advance.
//  push while CMD_FULL (and no pop): entry dropped, pointers/count unchanged, CMD_ERR<=1.
//  push with AWSLV >= SLV_NUM: stored as SLV_NUM-1 (decerr slave), CMD_ERR<=1.
//  Routing (combinational from registered head): head = mem[rd_ptr].
//   !CMD_EMPTY: S_WVALID[head]=WVALID, other bits 0; WREADY=S_WREADY[head].
//   CMD_EMPTY:  S_WVALID=0, WREADY=0 (W before its AW stalls; no bypass).
//  Latency: AW accepted in cycle N -> its W beats routable from cycle N+1.
//  Beats of one burst never split across slaves; head changes only after pop.
//  S_WDATA/S_WSTRB/S_WLAST = WDATA/WSTRB/WLAST unconditionally.
//  CMD_ERR clears only on reset.
//  Reset mid-burst: queue flushed immediately; partial bursts are not completed.
// TESTING
//  1. Reset, AW to slave 1 in cycle 0, 4-beat W (S_WREADY=all 1) -> S_WVALID=3'b010 cycles 1-4,
//     pop on beat 4, CMD_EMPTY=1 cycle 5.
//  2. W valid with queue empty for 5 cycles, then AW slave 0 -> WREADY=0 and S_WVALID=0 for the 5 cycles,
//     routing to slave 0 the cycle after AW.
//  3. 4 AWs to slaves 2,0,1,2 with W held -> CMD_FULL=1 after 4th; 1-beat bursts drain in order 2,0,1,2.
//  4. Full queue, AW handshake and WLAST pop same cycle -> count stays 4, CMD_FULL stays 1, CMD_ERR=0.
//  5. Forced AW handshake while full, or AWSLV=3 -> CMD_ERR=1 sticky; AWSLV=3 burst routed to slave 2.
//  6. Reset asserted mid-burst (beat 2 of 4) -> S_WVALID=0, CMD_EMPTY=1 asynchronously, CMD_ERR=0.

Source files
------------

// File: rtl/ic_wdata_route.sv
// ---------------------------------------------------------------------------
// ic_wdata_route
//
// Write-data router for one master W channel feeding SLV_NUM slave W ports.
// The last slave port (index SLV_NUM-1) is the decode-error slave.
//
// Every accepted AW pushes its decoded slave index into an in-order command
// queue. The W burst at the master is steered to the slave named at the
// queue head. The head entry is popped on the WLAST handshake, so the beats
// of one burst never split across slaves.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid
// and ready are both high. Valid never waits on ready. Here that means:
//   - AW push : AWVALID & AWREADY (observed only; the fabric gates AWREADY
//               with ~CMD_FULL)
//   - W beat  : WVALID & WREADY, and WREADY mirrors S_WREADY of the head
//               slave
//   - W pop   : a W beat with WLAST high
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   AWVALID, AWREADY    master AW handshake (observed)
//   AWSLV               decoded slave index for the current AW
//   WVALID/WDATA/WSTRB/WLAST   master W channel in
//   WREADY              master W ready out
//   S_WVALID            one-hot per-slave W valid
//   S_WREADY            per-slave W ready
//   S_WDATA/S_WSTRB/S_WLAST    broadcast W payload to all slaves
//   CMD_FULL, CMD_EMPTY command queue status (derived from the registered
//                       count)
//   CMD_ERR             sticky: push while full, or out-of-range AWSLV
// ---------------------------------------------------------------------------
module ic_wdata_route #(
  parameter int SLV_NUM   = 3,
  parameter int SLV_BITS  = 2,
  parameter int CMD_DEPTH = 4,
  parameter int DATA_BITS = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   AWVALID,
  input  logic                   AWREADY,
  input  logic [SLV_BITS-1:0]    AWSLV,
  input  logic                   WVALID,
  input  logic [DATA_BITS-1:0]   WDATA,
  input  logic [DATA_BITS/8-1:0] WSTRB,
  input  logic                   WLAST,
  output logic                   WREADY,
  output logic [SLV_NUM-1:0]     S_WVALID,
  input  logic [SLV_NUM-1:0]     S_WREADY,
  output logic [DATA_BITS-1:0]   S_WDATA,
  output logic [DATA_BITS/8-1:0] S_WSTRB,
  output logic                   S_WLAST,
  output logic                   CMD_FULL,
  output logic                   CMD_EMPTY,
  output logic                   CMD_ERR
);

  localparam int PTR_BITS = $clog2(CMD_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [SLV_BITS-1:0] DEC_IDX   = SLV_BITS'(SLV_NUM - 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL  = CNT_BITS'(CMD_DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  logic [SLV_BITS-1:0] mem_q [CMD_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                err_q, err_d;

  logic                push, pop, push_ok, bad_idx;
  logic [SLV_BITS-1:0] push_slv;
  logic [SLV_BITS-1:0] head;

  assign CMD_FULL  = (count_q == CNT_FULL);
  assign CMD_EMPTY = (count_q == '0);
  assign CMD_ERR   = err_q;

  assign push = AWVALID & AWREADY;
  // WREADY is forced low while empty, so a pop implies a valid head entry.
  assign pop  = WVALID & WREADY & WLAST;

  // A pop in the same cycle frees the slot, so a push into a full queue is
  // only dropped when nothing leaves.
  assign push_ok  = push & (~CMD_FULL | pop);
  assign bad_idx  = (AWSLV > DEC_IDX);
  assign push_slv = bad_idx ? DEC_IDX : AWSLV;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push & ~push_ok) err_d = 1'b1;
    if (push & bad_idx)  err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_slv;
    end
  end

  // Routing is purely from registered state, so an AW accepted in cycle N
  // steers W from cycle N+1. There is no AW->W bypass.
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    S_WVALID = '0;
    WREADY   = 1'b0;
    if (!CMD_EMPTY) begin
      S_WVALID[head] = WVALID;
      WREADY         = S_WREADY[head];
    end
  end

  assign S_WDATA = WDATA;
  assign S_WSTRB = WSTRB;
  assign S_WLAST = WLAST;

endmodule

// File: tb/tb_ic_wdata_route.sv
module tb_ic_wdata_route;

  logic        clk = 1'b0;
  logic        reset;
  logic        AWVALID, AWREADY;
  logic [1:0]  AWSLV;
  logic        WVALID;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WREADY;
  logic [2:0]  S_WVALID;
  logic [2:0]  S_WREADY;
  logic [63:0] S_WDATA;
  logic [7:0]  S_WSTRB;
  logic        S_WLAST;
  logic        CMD_FULL, CMD_EMPTY, CMD_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  ic_wdata_route #(
    .SLV_NUM(3), .SLV_BITS(2), .CMD_DEPTH(4), .DATA_BITS(64)
  ) dut (
    .clk(clk), .reset(reset),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWSLV(AWSLV),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WREADY(WREADY),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .CMD_FULL(CMD_FULL), .CMD_EMPTY(CMD_EMPTY), .CMD_ERR(CMD_ERR)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change on the falling edge, outputs are checked
  // 1 ns later, and the state updates on the following rising edge.
  task automatic idle();
    AWVALID = 1'b0; AWREADY = 1'b0; AWSLV = 2'd0;
    WVALID  = 1'b0; WLAST   = 1'b0;
    WDATA   = 64'h0; WSTRB  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); S_WREADY = 3'b111; reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic drive_aw(input logic [1:0] s);
    @(negedge clk); idle(); AWVALID = 1'b1; AWREADY = 1'b1; AWSLV = s;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); S_WREADY = 3'b111; WVALID = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", CMD_EMPTY); end
    n_checks++; if (CMD_FULL !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", CMD_FULL); end
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", CMD_ERR); end
    n_checks++; if (S_WVALID !== 3'b000) begin n_fail++; $display("FAIL rst_swvalid got %b want 000", S_WVALID); end
    n_checks++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL rst_wready got %b want 0", WREADY); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (WREADY !== 1'b0 || S_WVALID !== 3'b000) begin
      n_fail++; $display("FAIL post_rst_route got wready=%b swvalid=%b want 0/000", WREADY, S_WVALID); end
    @(negedge clk); idle();
  endtask

  task automatic test_single_burst();
    logic [63:0] exp_data;
    logic [7:0]  exp_strb;
    drive_aw(2'd1); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1) begin n_fail++; $display("FAIL sb_empty_same_cycle got %b want 1", CMD_EMPTY); end
    for (int b = 0; b < 4; b++) begin
      exp_data = 64'hA5A5_0000_0000_0000 + 64'(b);
      exp_strb = 8'hF0 + 8'(b);
      @(negedge clk); idle();
      WVALID = 1'b1; WDATA = exp_data; WSTRB = exp_strb; WLAST = (b == 3);
      #1;
      n_checks++; if (S_WVALID !== 3'b010) begin n_fail++; $display("FAIL sb_swvalid beat %0d got %b want 010", b, S_WVALID); end
      n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL sb_wready beat %0d got %b want 1", b, WREADY); end
      n_checks++; if (S_WDATA !== exp_data || S_WSTRB !== exp_strb) begin
        n_fail++; $display("FAIL sb_payload beat %0d got %h/%h want %h/%h", b, S_WDATA, S_WSTRB, exp_data, exp_strb); end
      n_checks++; if (S_WLAST !== (b == 3)) begin n_fail++; $display("FAIL sb_wlast beat %0d got %b want %b", b, S_WLAST, (b == 3)); end
      n_checks++; if (CMD_EMPTY !== 1'b0) begin n_fail++; $display("FAIL sb_not_empty beat %0d got %b want 0", b, CMD_EMPTY); end
    end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1) begin n_fail++; $display("FAIL sb_empty_after got %b want 1", CMD_EMPTY); end
    n_checks++; if (S_WVALID !== 3'b000) begin n_fail++; $display("FAIL sb_swvalid_after got %b want 000", S_WVALID); end
  endtask

  task automatic test_w_before_aw();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle(); WVALID = 1'b1; WLAST = 1'b1; #1;
      n_checks++; if (WREADY !== 1'b0 || S_WVALID !== 3'b000) begin
        n_fail++; $display("FAIL wb_stall cyc %0d got wready=%b swvalid=%b want 0/000", i, WREADY, S_WVALID); end
    end
    @(negedge clk); idle(); AWVALID = 1'b1; AWREADY = 1'b1; AWSLV = 2'd0;
    WVALID = 1'b1; WLAST = 1'b1; #1;
    n_checks++; if (WREADY !== 1'b0 || S_WVALID !== 3'b000) begin
      n_fail++; $display("FAIL wb_no_bypass got wready=%b swvalid=%b want 0/000", WREADY, S_WVALID); end
    @(negedge clk); idle(); WVALID = 1'b1; WLAST = 1'b1; #1;
    n_checks++; if (S_WVALID !== 3'b001 || WREADY !== 1'b1) begin
      n_fail++; $display("FAIL wb_route got swvalid=%b wready=%b want 001/1", S_WVALID, WREADY); end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1) begin n_fail++; $display("FAIL wb_empty got %b want 1", CMD_EMPTY); end
  endtask

  task automatic test_fill_drain();
    logic [1:0] order [4];
    logic [2:0] exp_oh;
    order = '{2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      drive_aw(order[i]); #1;
      n_checks++; if (CMD_FULL !== 1'b0) begin n_fail++; $display("FAIL fd_not_full push %0d got %b want 0", i, CMD_FULL); end
    end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_FULL !== 1'b1) begin n_fail++; $display("FAIL fd_full got %b want 1", CMD_FULL); end
    n_checks++; if (S_WVALID !== 3'b000) begin n_fail++; $display("FAIL fd_w_held got %b want 000", S_WVALID); end
    for (int i = 0; i < 4; i++) begin
      exp_oh = 3'b001 << order[i];
      @(negedge clk); idle(); WVALID = 1'b1; WLAST = 1'b1; #1;
      n_checks++; if (S_WVALID !== exp_oh) begin n_fail++; $display("FAIL fd_drain %0d got %b want %b", i, S_WVALID, exp_oh); end
    end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1 || CMD_FULL !== 1'b0) begin
      n_fail++; $display("FAIL fd_final got empty=%b full=%b want 1/0", CMD_EMPTY, CMD_FULL); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] fill [4];
    logic [1:0] drain [4];
    logic [2:0] exp_oh;
    fill  = '{2'd0, 2'd1, 2'd2, 2'd0};
    drain = '{2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) drive_aw(fill[i]);
    @(negedge clk); idle(); AWVALID = 1'b1; AWREADY = 1'b1; AWSLV = 2'd1;
    WVALID = 1'b1; WLAST = 1'b1; #1;
    n_checks++; if (CMD_FULL !== 1'b1 || S_WVALID !== 3'b001) begin
      n_fail++; $display("FAIL fpp_pre got full=%b swvalid=%b want 1/001", CMD_FULL, S_WVALID); end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_FULL !== 1'b1) begin n_fail++; $display("FAIL fpp_full_kept got %b want 1", CMD_FULL); end
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL fpp_err got %b want 0", CMD_ERR); end
    for (int i = 0; i < 4; i++) begin
      exp_oh = 3'b001 << drain[i];
      @(negedge clk); idle(); WVALID = 1'b1; WLAST = 1'b1; #1;
      n_checks++; if (S_WVALID !== exp_oh) begin n_fail++; $display("FAIL fpp_drain %0d got %b want %b", i, S_WVALID, exp_oh); end
    end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %b want 1", CMD_EMPTY); end
  endtask

  task automatic test_bad_index();
    do_reset();
    drive_aw(2'd3);
    @(negedge clk); idle(); S_WREADY = 3'b011; WVALID = 1'b1; WLAST = 1'b1; #1;
    n_checks++; if (CMD_ERR !== 1'b1) begin n_fail++; $display("FAIL bi_err got %b want 1", CMD_ERR); end
    n_checks++; if (S_WVALID !== 3'b100) begin n_fail++; $display("FAIL bi_route got %b want 100", S_WVALID); end
    n_checks++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL bi_wready_low got %b want 0", WREADY); end
    @(negedge clk); idle(); S_WREADY = 3'b100; WVALID = 1'b1; WLAST = 1'b1; #1;
    n_checks++; if (WREADY !== 1'b1 || S_WVALID !== 3'b100) begin
      n_fail++; $display("FAIL bi_wready_high got wready=%b swvalid=%b want 1/100", WREADY, S_WVALID); end
    @(negedge clk); idle(); S_WREADY = 3'b111; #1;
    n_checks++; if (CMD_EMPTY !== 1'b1 || CMD_ERR !== 1'b1) begin
      n_fail++; $display("FAIL bi_sticky got empty=%b err=%b want 1/1", CMD_EMPTY, CMD_ERR); end
  endtask

  task automatic test_overflow();
    do_reset(); #1;
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL ov_err_clear got %b want 0", CMD_ERR); end
    for (int i = 0; i < 4; i++) drive_aw(2'd0);
    drive_aw(2'd1);
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_ERR !== 1'b1 || CMD_FULL !== 1'b1) begin
      n_fail++; $display("FAIL ov_err got err=%b full=%b want 1/1", CMD_ERR, CMD_FULL); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); WVALID = 1'b1; WLAST = 1'b1; #1;
      n_checks++; if (S_WVALID !== 3'b001) begin n_fail++; $display("FAIL ov_drain %0d got %b want 001", i, S_WVALID); end
    end
    @(negedge clk); idle(); #1;
    n_checks++; if (CMD_EMPTY !== 1'b1) begin n_fail++; $display("FAIL ov_dropped got empty=%b want 1", CMD_EMPTY); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive_aw(2'd3);
    @(negedge clk); idle(); WVALID = 1'b1; WDATA = 64'h1; #1;
    n_checks++; if (S_WVALID !== 3'b100 || CMD_ERR !== 1'b1) begin
      n_fail++; $display("FAIL rm_beat1 got swvalid=%b err=%b want 100/1", S_WVALID, CMD_ERR); end
    @(negedge clk); idle(); WVALID = 1'b1; WDATA = 64'h2; #1;
    n_checks++; if (S_WVALID !== 3'b100) begin n_fail++; $display("FAIL rm_beat2 got %b want 100", S_WVALID); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (S_WVALID !== 3'b000 || WREADY !== 1'b0) begin
      n_fail++; $display("FAIL rm_async_route got swvalid=%b wready=%b want 000/0", S_WVALID, WREADY); end
    n_checks++; if (CMD_EMPTY !== 1'b1 || CMD_ERR !== 1'b0) begin
      n_fail++; $display("FAIL rm_async_state got empty=%b err=%b want 1/0", CMD_EMPTY, CMD_ERR); end
    @(negedge clk); reset = 1'b0; idle(); WVALID = 1'b1; WDATA = 64'h3; #1;
    n_checks++; if (S_WVALID !== 3'b000) begin n_fail++; $display("FAIL rm_no_resume got %b want 000", S_WVALID); end
    @(negedge clk); idle();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_w_before_aw();
    test_fill_drain();
    test_full_push_pop();
    test_bad_index();
    test_overflow();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
